// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared definitions for the keypad scan controller: host port numbers,
// debounce states, frame classification results and row-decoding helpers.
package keypad_scan_ctrl_pkg;

   localparam logic [7:0]  KEY_CODE_PORT = 8'h06;
   localparam logic [7:0]  KEY_STAT_PORT = 8'h07;
   localparam int unsigned KEY_CODE_W    = 8;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PRESS_CHK,
      ST_HELD,
      ST_RELEASE_CHK
   } deb_state_t;

   typedef enum logic [1:0] {
      FR_NONE,
      FR_SINGLE,
      FR_MULTI
   } frame_res_t;

   // Number of low (pressed) rows, saturated at 2 since only 0/1/many matters.
   function automatic logic [1:0] low_count(input logic [3:0] rows);
      logic [2:0] n;
      n = '0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (!rows[i]) n = n + 3'd1;
      end
      return (n > 3'd1) ? 2'd2 : n[1:0];
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] rows);
      logic [1:0] idx;
      idx = '0;
      for (int unsigned i = 4; i > 0; i--) begin
         if (!rows[i-1]) idx = 2'(i - 1);
      end
      return idx;
   endfunction

endpackage

// File: rtl/keypad_scan_ctrl_fifo.sv
// Small synchronous FIFO for accepted key codes; the head is registered so a
// pushed code appears on o_dout one cycle after the push.
module key_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     pb_reset,
   input  logic                     i_push,
   input  logic                     i_pop,
   input  logic [WIDTH-1:0]         i_din,
   output logic [WIDTH-1:0]         o_dout,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
   logic [CNT_W-1:0] r_count;
   logic [WIDTH-1:0] r_dout;

   logic             w_do_pop, w_do_push;
   logic [PTR_W-1:0] w_rd_nxt;
   logic [CNT_W-1:0] w_remain, w_cnt_nxt;
   logic [WIDTH-1:0] w_dout_nxt;

   always_comb begin
      w_do_pop   = i_pop && (r_count != '0);
      w_do_push  = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);
      w_rd_nxt   = r_rd_ptr + PTR_W'(w_do_pop);
      w_remain   = r_count - CNT_W'(w_do_pop);
      w_cnt_nxt  = w_remain + CNT_W'(w_do_push);
      // If nothing older survives the pop, the new head is the word being pushed.
      if (w_cnt_nxt == '0)      w_dout_nxt = '0;
      else if (w_remain == '0)  w_dout_nxt = i_din;
      else                      w_dout_nxt = r_mem[w_rd_nxt];
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_din;
   end

   always_ff @(posedge clk or posedge pb_reset) begin
      if (pb_reset) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
         r_dout   <= '0;
      end else begin
         r_rd_ptr <= w_rd_nxt;
         r_wr_ptr <= r_wr_ptr + PTR_W'(w_do_push);
         r_count  <= w_cnt_nxt;
         r_dout   <= w_dout_nxt;
      end
   end

   assign o_dout  = r_dout;
   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: column drive, row synchroniser, per-frame single-key
// classification, press/release debounce and key-code queue for the host.
module keypad_scan_ctrl
   import keypad_scan_ctrl_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 100000,
   parameter int unsigned DEBOUNCE_SCANS = 4,
   parameter int unsigned FIFO_DEPTH     = 4
) (
   input  logic                  clk,
   input  logic                  pb_reset,
   input  logic [3:0]            row,
   output logic [3:0]            col,
   output logic [KEY_CODE_W-1:0] key_code,
   output logic                  key_present,
   output logic                  overflow,
   input  logic                  key_read_ack,
   input  logic                  ovf_clear
);

   localparam int unsigned DIV_W  = $clog2(SCAN_DIV);
   localparam int unsigned CNT_W  = ($clog2(DEBOUNCE_SCANS + 1) > 3) ? $clog2(DEBOUNCE_SCANS + 1) : 3;
   localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [3:0]       r_row_s1, r_row_s2;
   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_col_idx;
   logic [1:0]       r_acc_cnt;
   logic [3:0]       r_acc_code;
   deb_state_t       r_state, w_state_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [3:0]       r_cand, w_cand_nxt;
   logic             r_overflow;

   logic             w_tc, w_frame_end, w_push, w_drop, w_full, w_empty;
   logic [1:0]       w_col_low, w_frm_cnt;
   logic [2:0]       w_sum;
   logic [3:0]       w_col_code, w_frm_code;
   frame_res_t       w_res;
   logic [FCNT_W-1:0] w_fifo_count;

   assign w_tc        = (r_div == DIV_W'(SCAN_DIV - 1));
   assign w_frame_end = w_tc && (r_col_idx == 2'd3);
   assign col         = ~(4'b0001 << r_col_idx);

   // The frame result includes the column being sampled on this same edge.
   always_comb begin
      w_col_low  = low_count(r_row_s2);
      w_col_code = {r_col_idx, low_index(r_row_s2)};
      w_sum      = {1'b0, r_acc_cnt} + {1'b0, w_col_low};
      w_frm_cnt  = (w_sum > 3'd1) ? 2'd2 : w_sum[1:0];
      w_frm_code = (r_acc_cnt == 2'd0) ? w_col_code : r_acc_code;
      case (w_frm_cnt)
         2'd0:    w_res = FR_NONE;
         2'd1:    w_res = FR_SINGLE;
         default: w_res = FR_MULTI;
      endcase
   end

   always_ff @(posedge clk or posedge pb_reset) begin
      if (pb_reset) begin
         r_row_s1   <= 4'b1111;
         r_row_s2   <= 4'b1111;
         r_div      <= '0;
         r_col_idx  <= '0;
         r_acc_cnt  <= '0;
         r_acc_code <= '0;
      end else begin
         r_row_s1 <= row;
         r_row_s2 <= r_row_s1;
         if (w_tc) begin
            r_div     <= '0;
            r_col_idx <= r_col_idx + 2'd1;
            if (w_frame_end) begin
               r_acc_cnt  <= '0;
               r_acc_code <= '0;
            end else begin
               r_acc_cnt  <= w_frm_cnt;
               r_acc_code <= w_frm_code;
            end
         end else begin
            r_div <= r_div + DIV_W'(1);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_cand_nxt  = r_cand;
      w_push      = 1'b0;
      w_cnt_inc   = r_cnt + CNT_W'(1);
      if (w_frame_end) begin
         case (r_state)
            ST_IDLE: begin
               if (w_res == FR_SINGLE) begin
                  w_state_nxt = ST_PRESS_CHK;
                  w_cand_nxt  = w_frm_code;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
            ST_PRESS_CHK: begin
               if ((w_res == FR_SINGLE) && (w_frm_code == r_cand)) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == CNT_W'(DEBOUNCE_SCANS)) begin
                     w_push      = 1'b1;
                     w_state_nxt = ST_HELD;
                  end
               end else begin
                  w_state_nxt = ST_IDLE;
               end
            end
            ST_HELD: begin
               if (w_res == FR_NONE) begin
                  w_state_nxt = ST_RELEASE_CHK;
                  w_cnt_nxt   = CNT_W'(1);
               end
            end
            ST_RELEASE_CHK: begin
               if (w_res == FR_NONE) begin
                  w_cnt_nxt = w_cnt_inc;
                  if (w_cnt_inc == CNT_W'(DEBOUNCE_SCANS)) w_state_nxt = ST_IDLE;
               end else begin
                  w_state_nxt = ST_HELD;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge pb_reset) begin
      if (pb_reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_cand  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_cand  <= w_cand_nxt;
      end
   end

   key_fifo #(
      .WIDTH (KEY_CODE_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .pb_reset (pb_reset),
      .i_push   (w_push),
      .i_pop    (key_read_ack),
      .i_din    ({{(KEY_CODE_W - 4){1'b0}}, r_cand}),
      .o_dout   (key_code),
      .o_full   (w_full),
      .o_empty  (w_empty),
      .o_count  (w_fifo_count)
   );

   assert property (@(posedge clk) disable iff (pb_reset) (w_fifo_count == '0) == w_empty);

   // A pop on the same edge frees a slot, so only an unpaired push into a full queue is lost.
   assign w_drop = w_push && w_full && !key_read_ack;

   always_ff @(posedge clk or posedge pb_reset) begin
      if (pb_reset)       r_overflow <= 1'b0;
      else if (w_drop)    r_overflow <= 1'b1;
      else if (ovf_clear) r_overflow <= 1'b0;
   end

   assign overflow    = r_overflow;
   assign key_present = !w_empty;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl with a behavioural 4x4 key matrix.
module tb_keypad_scan_ctrl;

   logic       clk = 1'b0;
   logic       pb_reset;
   logic [3:0] row;
   logic [3:0] col;
   logic [7:0] key_code;
   logic       key_present;
   logic       overflow;
   logic       key_read_ack;
   logic       ovf_clear;
   logic [15:0] keys_down;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   keypad_scan_ctrl #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk          (clk),
      .pb_reset     (pb_reset),
      .row          (row),
      .col          (col),
      .key_code     (key_code),
      .key_present  (key_present),
      .overflow     (overflow),
      .key_read_ack (key_read_ack),
      .ovf_clear    (ovf_clear)
   );

   always #5 clk = ~clk;

   // Pressed key at (c,r) pulls row r low while column c is driven low.
   always_comb begin
      row = 4'hF;
      for (int c = 0; c < 4; c++) begin
         if (col[c] == 1'b0) begin
            for (int r = 0; r < 4; r++) begin
               if (keys_down[c*4 + r]) row[r] = 1'b0;
            end
         end
      end
   end

   typedef struct {
      logic [15:0] keys;
      int unsigned frames;
      logic        ack;
      logic        clr;
      logic        exp_present;
      logic [7:0]  exp_code;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[24];

   function automatic logic [15:0] K(input int code);
      logic [15:0] one;
      one = 16'h0001;
      return one << code;
   endfunction

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %02h expected %02h", name, got, exp);
      end
   endtask

   task automatic wait_neg(input int unsigned n);
      repeat (n) @(negedge clk);
   endtask

   // Press for two frames (push on the second frame end), optionally acking on
   // that same edge, then release for two frames; returns frame-aligned.
   task automatic press_code(input int code, input logic ack_at_push);
      keys_down = K(code);
      wait_neg(16 + 15);
      key_read_ack = ack_at_push;
      wait_neg(1);
      key_read_ack = 1'b0;
      keys_down = '0;
      wait_neg(32);
   endtask

   initial begin
      vecs[0]  = '{K(9),        3,  1'b0, 1'b0, 1'b1, 8'h09, 1'b0};
      vecs[1]  = '{K(9),        10, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0};
      vecs[2]  = '{16'h0000,    2,  1'b0, 1'b0, 1'b1, 8'h09, 1'b0};
      vecs[3]  = '{16'h0000,    1,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[4]  = '{K(7),        1,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[5]  = '{16'h0000,    2,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[6]  = '{K(0) | K(5), 5,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[7]  = '{16'h0000,    1,  1'b0, 1'b0, 1'b0, 8'h00, 1'b0};
      vecs[8]  = '{K(0),        2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[9]  = '{16'h0000,    2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[10] = '{K(5),        2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[11] = '{16'h0000,    2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[12] = '{K(10),       2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[13] = '{16'h0000,    2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[14] = '{K(15),       2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[15] = '{16'h0000,    2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b0};
      vecs[16] = '{K(3),        2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
      vecs[17] = '{16'h0000,    2,  1'b0, 1'b0, 1'b1, 8'h00, 1'b1};
      vecs[18] = '{16'h0000,    1,  1'b1, 1'b0, 1'b1, 8'h05, 1'b1};
      vecs[19] = '{16'h0000,    1,  1'b1, 1'b0, 1'b1, 8'h0A, 1'b1};
      vecs[20] = '{16'h0000,    1,  1'b1, 1'b0, 1'b1, 8'h0F, 1'b1};
      vecs[21] = '{16'h0000,    1,  1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
      vecs[22] = '{16'h0000,    1,  1'b0, 1'b1, 1'b0, 8'h00, 1'b0};
      vecs[23] = '{16'h0000,    1,  1'b1, 1'b0, 1'b0, 8'h00, 1'b0};

      keys_down    = '0;
      key_read_ack = 1'b0;
      ovf_clear    = 1'b0;
      pb_reset     = 1'b0;
      #1 pb_reset  = 1'b1;
      #11;
      chk("reset_col",     {4'h0, col}, 8'h0E);
      chk("reset_present", {7'h0, key_present}, 8'h00);
      chk("reset_code",    key_code, 8'h00);
      chk("reset_ovf",     {7'h0, overflow}, 8'h00);

      @(negedge clk);
      pb_reset = 1'b0;
      for (int k = 0; k < 32; k++) begin
         logic [3:0] one4;
         one4 = 4'b0001;
         chk($sformatf("col_rot[%0d]", k), {4'h0, col}, {4'h0, ~(one4 << ((k / 4) % 4))});
         @(negedge clk);
      end

      for (int i = 0; i < 24; i++) begin
         int unsigned remaining;
         keys_down = vecs[i].keys;
         remaining = 16 * vecs[i].frames;
         if (vecs[i].ack || vecs[i].clr) begin
            key_read_ack = vecs[i].ack;
            ovf_clear    = vecs[i].clr;
            @(negedge clk);
            key_read_ack = 1'b0;
            ovf_clear    = 1'b0;
            remaining    = remaining - 1;
         end
         wait_neg(remaining);
         chk($sformatf("vec%0d_present", i), {7'h0, key_present}, {7'h0, vecs[i].exp_present});
         chk($sformatf("vec%0d_code", i),    key_code, vecs[i].exp_code);
         chk($sformatf("vec%0d_ovf", i),     {7'h0, overflow}, {7'h0, vecs[i].exp_ovf});
      end

      press_code(14, 1'b1);
      chk("empty_pushpop_present", {7'h0, key_present}, 8'h01);
      chk("empty_pushpop_code",    key_code, 8'h0E);

      press_code(1, 1'b0);
      press_code(2, 1'b0);
      press_code(4, 1'b0);
      press_code(8, 1'b1);
      chk("full_pushpop_code", key_code, 8'h01);
      chk("full_pushpop_ovf",  {7'h0, overflow}, 8'h00);

      press_code(9, 1'b0);
      chk("full_drop_ovf",  {7'h0, overflow}, 8'h01);
      chk("full_drop_code", key_code, 8'h01);

      keys_down = K(6);
      wait_neg(16 + 6);
      pb_reset = 1'b1;
      #1;
      chk("midreset_col",     {4'h0, col}, 8'h0E);
      chk("midreset_present", {7'h0, key_present}, 8'h00);
      chk("midreset_code",    key_code, 8'h00);
      chk("midreset_ovf",     {7'h0, overflow}, 8'h00);
      @(negedge clk);
      keys_down = '0;
      pb_reset  = 1'b0;
      wait_neg(48);
      chk("after_reset_present", {7'h0, key_present}, 8'h00);
      chk("after_reset_code",    key_code, 8'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
